// File: rtl/multi_ch_clock_divider.sv
// multi_ch_clock_divider: NUM_CH independent 50%-duty clock dividers with programmable half-period,
// shadowed config applied only at period boundaries, global phase-align and rise/fall strobes.
module multi_ch_clock_divider #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 14,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] fall_stb,
    output logic [NUM_CH-1:0] cfg_pending
);
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d, h_q, h_d, sh_q, sh_d;
            logic div_q, div_d, rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
            logic wr, tc, run, apply;
            always_comb begin
                wr     = cfg_wr && (cfg_ch == CH_W'(g));
                run    = ch_en[g] && !sync;
                tc     = cnt_q == h_q;
                // H may only change when the channel is idle, re-phased, or at the end of a high phase
                apply  = !run || (tc && div_q);
                cnt_d  = (!run || tc) ? '0 : cnt_q + CNT_W'(1);
                div_d  = run && (tc ? !div_q : div_q);
                rise_d = run && tc && !div_q;
                fall_d = ch_en[g] && div_q && (sync || tc);
                sh_d   = wr ? cfg_half : sh_q;
                h_d    = !apply ? h_q : wr ? cfg_half : pend_q ? sh_q : h_q;
                pend_d = !apply && (wr || pend_q);
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q  <= '0;
                    h_q    <= CNT_W'(DEFAULT_HALF);
                    sh_q   <= CNT_W'(DEFAULT_HALF);
                    div_q  <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    h_q    <= h_d;
                    sh_q   <= sh_d;
                    div_q  <= div_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                    pend_q <= pend_d;
                end
            end
            assign div_out[g]     = div_q;
            assign rise_stb[g]    = rise_q;
            assign fall_stb[g]    = fall_q;
            assign cfg_pending[g] = pend_q;
        end
    endgenerate
endmodule

// File: tb/tb_multi_ch_clock_divider.sv
// tb_multi_ch_clock_divider: directed and random checks of the divider against a period-position model.
module tb_multi_ch_clock_divider;
    localparam int N  = 6;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  ch_en = '0;
    logic          sync = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [W-1:0]  cfg_half = '0;
    logic [N-1:0]  div_out, rise_stb, fall_stb, cfg_pending;

    multi_ch_clock_divider #(.NUM_CH(N), .CNT_W(W), .DEFAULT_HALF(14)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync), .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch), .cfg_half(cfg_half), .div_out(div_out),
        .rise_stb(rise_stb), .fall_stb(fall_stb), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Model: pos = counted cycles into the current period (0 .. 2H+1); high while pos > H.
    int pos[N], mh[N], msh[N];
    bit mpend[N];
    logic [N-1:0] e_div, e_rise, e_fall, e_pend;
    int checks = 0, failures = 0, cyc = 0;

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
        end
    endfunction

    function void model_reset();
        for (int i = 0; i < N; i++) begin
            pos[i] = 0; mh[i] = 14; msh[i] = 14; mpend[i] = 0;
        end
        e_div = '0; e_rise = '0; e_fall = '0; e_pend = '0;
    endfunction

    function void model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            bit wr, was_hi, wrap;
            wr = cfg_wr && (int'(cfg_ch) == i);
            was_hi = pos[i] > mh[i];
            wrap = 0;
            e_rise[i] = 0;
            e_fall[i] = 0;
            if (!ch_en[i] || sync) begin
                e_fall[i] = ch_en[i] && was_hi;
                pos[i] = 0;
                wrap = 1;
            end else begin
                pos[i]++;
                if (pos[i] == mh[i] + 1) e_rise[i] = 1;
                if (pos[i] == 2 * mh[i] + 2) begin
                    e_fall[i] = 1;
                    pos[i] = 0;
                    wrap = 1;
                end
            end
            if (wrap) begin
                if (wr) begin
                    mh[i] = int'(cfg_half);
                    msh[i] = int'(cfg_half);
                end else if (mpend[i]) mh[i] = msh[i];
                mpend[i] = 0;
            end else if (wr) begin
                msh[i] = int'(cfg_half);
                mpend[i] = 1;
            end
            e_div[i] = pos[i] > mh[i];
            e_pend[i] = mpend[i];
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("div_out", 32'(div_out), 32'(e_div));
        check("rise_stb", 32'(rise_stb), 32'(e_rise));
        check("fall_stb", 32'(fall_stb), 32'(e_fall));
        check("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    endtask

    task automatic wr_cfg(input int ch, input int h);
        cfg_wr = 1'b1;
        cfg_ch = CW'(ch);
        cfg_half = W'(h);
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_stb(input bit fall, input int ch, input int lim, output int t);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(fall ? fall_stb[ch] : rise_stb[ch]) && n < lim);
        check(fall ? "wait_fall" : "wait_rise", 32'(fall ? fall_stb[ch] : rise_stb[ch]), 1);
        t = cyc;
    endtask

    task automatic wait_idle(input int ch, input int lim);
        int n = 0;
        while (cfg_pending[ch] && n < lim) begin
            cycle();
            n++;
        end
        check("wait_apply", 32'(cfg_pending[ch]), 0);
    endtask

    initial begin
        int t0, t1, t2, t3, n;
        int first[N];
        logic prev;
        model_reset();
        repeat (3) cycle();
        check("rst_div", 32'(div_out), 0);
        check("rst_pend", 32'(cfg_pending), 0);
        rst = 1'b0;
        cycle();

        // default divide-by-30 on channel 0
        ch_en = 6'b000001;
        t0 = cyc;
        wait_stb(0, 0, 40, t1);
        check("d1_first_rise", 32'(t1 - t0), 15);
        wait_stb(1, 0, 40, t2);
        check("d1_high", 32'(t2 - t1), 15);
        wait_stb(0, 0, 40, t3);
        check("d1_period", 32'(t3 - t1), 30);
        check("d1_others_low", 32'(div_out[N-1:1]), 0);

        // shadowed write mid-high-phase
        repeat (5) cycle();
        wr_cfg(0, 3);
        check("d2_pending", 32'(cfg_pending[0]), 1);
        wait_stb(1, 0, 40, t1);
        check("d2_old_high", 32'(t1 - t3), 15);
        check("d2_pend_clr", 32'(cfg_pending[0]), 0);
        wait_stb(0, 0, 40, t2);
        check("d2_new_low", 32'(t2 - t1), 4);
        wait_stb(0, 0, 40, t3);
        check("d2_new_period", 32'(t3 - t2), 8);

        // disabled writes apply directly; sync phase-aligns everything
        ch_en = '0;
        for (int i = 0; i < N; i++) wr_cfg(i, i + 1);
        check("d3_direct", 32'(cfg_pending), 0);
        ch_en = '1;
        repeat (17) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("d3_sync_low", 32'(div_out), 0);
        t0 = cyc;
        for (int i = 0; i < N; i++) first[i] = -1;
        repeat (10) begin
            cycle();
            for (int i = 0; i < N; i++) if (rise_stb[i] && first[i] < 0) first[i] = cyc - t0;
        end
        for (int i = 0; i < N; i++) check("d3_rise_after_sync", 32'(first[i]), 32'(i + 2));

        // divide-by-2 then maximum half-period on channel 1
        wr_cfg(1, 0);
        wait_idle(1, 20);
        prev = div_out[1];
        repeat (6) begin
            cycle();
            check("d4_toggle", 32'(div_out[1]), 32'(!prev));
            prev = div_out[1];
        end
        wr_cfg(1, 255);
        wait_idle(1, 10);
        wait_stb(0, 1, 600, t1);
        wait_stb(0, 1, 600, t2);
        check("d4_period_512", 32'(t2 - t1), 512);

        // out-of-range channel writes are ignored
        wr_cfg(6, 9);
        wr_cfg(7, 9);
        check("d5_oob", 32'(cfg_pending), 0);

        // write coincident with period end applies immediately (ch2, H=3 -> 5)
        n = 0;
        while (pos[2] != 2 * mh[2] + 1 && n < 20) begin
            cycle();
            n++;
        end
        wr_cfg(2, 5);
        check("d5_coinc_fall", 32'(fall_stb[2]), 1);
        check("d5_coinc_pend", 32'(cfg_pending[2]), 0);
        t1 = cyc;
        wait_stb(0, 2, 40, t2);
        check("d5_new_low", 32'(t2 - t1), 6);

        // asynchronous reset mid-period with H=7
        wr_cfg(0, 7);
        wait_idle(0, 20);
        wait_stb(0, 0, 40, t1);
        repeat (2) cycle();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("d6_async_div", 32'(div_out), 0);
        check("d6_async_rise", 32'(rise_stb), 0);
        check("d6_async_fall", 32'(fall_stb), 0);
        check("d6_async_pend", 32'(cfg_pending), 0);
        repeat (2) cycle();
        rst = 1'b0;
        ch_en = 6'b000001;
        t0 = cyc;
        wait_stb(0, 0, 40, t1);
        check("d6_first_rise", 32'(t1 - t0), 15);
        wait_stb(0, 0, 40, t2);
        check("d6_period", 32'(t2 - t1), 30);

        // randomized traffic against the model
        ch_en = '1;
        repeat (3000) begin
            if ($urandom_range(31) == 0) ch_en[$urandom_range(N - 1)] ^= 1'b1;
            sync = ($urandom_range(49) == 0);
            cfg_wr = ($urandom_range(7) == 0);
            cfg_ch = CW'($urandom_range(7));
            cfg_half = ($urandom_range(15) == 0) ? W'($urandom_range(255)) : W'($urandom_range(7));
            cycle();
        end
        sync = 1'b0;
        cfg_wr = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
